// File: rtl/pl_iter_pkg.sv
// Shared definitions for the iterative divide/square-root arbiter: FSM states,
// shared-core opcodes, owner encoding and default iteration counts.
package pl_iter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_UDIV  = 2'b00;
  localparam logic [1:0] OP_SDIV  = 2'b01;
  localparam logic [1:0] OP_FDIV  = 2'b10;
  localparam logic [1:0] OP_FSQRT = 2'b11;

  localparam logic OWNER_INT = 1'b0;
  localparam logic OWNER_FP  = 1'b1;

  localparam int DEF_INT_ITERS   = 32;
  localparam int DEF_FDIV_ITERS  = 26;
  localparam int DEF_FSQRT_ITERS = 26;
  localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/pl_rr_arb2.sv
// Two-requester round-robin picker (INT vs FP) for the shared iterative core.
// On a tie the requester that did not win last time is chosen.
module pl_rr_arb2
  import pl_iter_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic req_int,
  input  logic req_fp,
  input  logic take,
  output logic gnt_valid,
  output logic gnt_owner
);

  logic last_grant;

  always_comb begin
    gnt_valid = req_int | req_fp;
    if (req_int && req_fp) begin
      gnt_owner = ~last_grant;
    end else if (req_fp) begin
      gnt_owner = OWNER_FP;
    end else begin
      gnt_owner = OWNER_INT;
    end
  end

  // Resetting to FP makes INT win the first tie after reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_grant <= OWNER_FP;
    end else if (take && gnt_valid) begin
      last_grant <= gnt_owner;
    end
  end

endmodule

// File: rtl/pl_iter_unit_arbiter.sv
// Arbiter and sequencer for the shared iterative div/sqrt core (INT M-ext vs FPU).
// Optional macro ITER_EARLY_OUT_EN: trivial integer ops skip the core and finish one cycle after grant.
module pl_iter_unit_arbiter
  import pl_iter_pkg::*;
#(
  parameter int INT_ITERS   = DEF_INT_ITERS,
  parameter int FDIV_ITERS  = DEF_FDIV_ITERS,
  parameter int FSQRT_ITERS = DEF_FSQRT_ITERS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       int_req,
  input  logic       int_signed,
  input  logic       int_rem,
  input  logic       int_trivial,
  input  logic       fp_req,
  input  logic       fp_sqrt,
  input  logic       int_kill,
  input  logic       fp_kill,
  output logic       core_start,
  output logic       core_en,
  output logic [1:0] core_op,
  output logic       core_rem,
  output logic       owner,
  output logic       busy,
  output logic       int_done,
  output logic       fp_done,
  output logic       int_wait,
  output logic       fp_wait
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             gnt_valid;
  logic             gnt_owner;
  logic [1:0]       gnt_op;
  logic [CNT_W-1:0] gnt_cnt;
  logic             gnt_trivial;
  logic             owner_kill;

  assign take = (state == IDLE);

  pl_rr_arb2 u_arb (
    .clk       (clk),
    .clr       (clr),
    .req_int   (int_req),
    .req_fp    (fp_req),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  always_comb begin
    gnt_op  = int_signed ? OP_SDIV : OP_UDIV;
    gnt_cnt = CNT_W'(INT_ITERS - 1);
    if (gnt_owner == OWNER_FP) begin
      gnt_op  = fp_sqrt ? OP_FSQRT : OP_FDIV;
      gnt_cnt = fp_sqrt ? CNT_W'(FSQRT_ITERS - 1) : CNT_W'(FDIV_ITERS - 1);
    end
  end

`ifdef ITER_EARLY_OUT_EN
  assign gnt_trivial = (gnt_owner == OWNER_INT) & int_trivial;
`else
  logic unused_trivial;
  assign unused_trivial = int_trivial;
  assign gnt_trivial    = 1'b0;
`endif

  assign owner_kill = (owner == OWNER_FP) ? fp_kill : int_kill;

  // Single FSM plus iteration counter; a kill of the current owner aborts straight to IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= OWNER_INT;
      core_op  <= OP_UDIV;
      core_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner    <= gnt_owner;
            core_op  <= gnt_op;
            core_rem <= (gnt_owner == OWNER_INT) & int_rem;
            cnt      <= gnt_cnt;
            state    <= gnt_trivial ? DONE : START;
          end
        end
        START: state <= owner_kill ? IDLE : BUSY;
        BUSY: begin
          if (owner_kill) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // Kill gating is combinational so an aborted op never shows an extra iteration or a done.
  assign busy       = (state != IDLE);
  assign core_start = (state == START);
  assign core_en    = (state == BUSY) & ~owner_kill;
  assign int_done   = (state == DONE) & (owner == OWNER_INT) & ~int_kill;
  assign fp_done    = (state == DONE) & (owner == OWNER_FP) & ~fp_kill;
  assign int_wait   = int_req & ~int_done;
  assign fp_wait    = fp_req & ~fp_done;

endmodule
